// File: rtl/core_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// core_run_ctrl_if
//   Command port between the debug/GPIO front end and the run/halt/step
//   sequencer. Plain valid/ready handshake; a command transfers on a cycle
//   where cmd_valid and cmd_ready are both high.
//
//   Signals
//     cmd_valid  front end -> sequencer  command present
//     cmd_ready  sequencer -> front end  command can be taken this cycle
//     cmd_op     front end -> sequencer  00 HALT, 01 RUN, 10 STEP, 11 SET_BP
//     cmd_data   front end -> sequencer  STEP: count-1; SET_BP: [7]=enable,
//                                        low bits = breakpoint word address
//
//   Modports
//     master  front end side
//     slave   sequencer side
// -----------------------------------------------------------------------------
interface core_run_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface : core_run_ctrl_if

// File: rtl/core_run_ctrl.sv
// -----------------------------------------------------------------------------
// core_run_ctrl
//   Run/halt/single-step sequencer for tiny_core. Produces a per-cycle enable
//   for the core's PC and register-file updates, accepts commands from the
//   debug front end, and stops on a single PC breakpoint.
//
//   Parameters
//     ROM_ADDR_BITS  width of the instruction word address (pc_word_i)
//
//   Ports
//     clk        in   clock
//     reset      in   synchronous, active-high reset
//     cmd        if   command port (core_run_ctrl_if.slave)
//     pc_word_i  in   current core PC word index
//     core_en_o  out  core advances one instruction this cycle
//     halted_o   out  sequencer is in HALT
//     bp_hit_o   out  sticky: the last stop was caused by the breakpoint
//     instret_o  out  retired-instruction count
//
//   Build option
//     RUN_CTRL_INSTRET_EN  when defined, instret_o counts core_en cycles and
//                          saturates at 16'hFFFF; when undefined the output
//                          is tied to zero and no counter is built.
// -----------------------------------------------------------------------------
module core_run_ctrl #(
  parameter int ROM_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  core_run_ctrl_if.slave           cmd,
  input  logic [ROM_ADDR_BITS-1:0] pc_word_i,
  output logic                     core_en_o,
  output logic                     halted_o,
  output logic                     bp_hit_o,
  output logic [15:0]              instret_o
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_e;

  localparam logic [1:0] OP_HALT   = 2'b00;
  localparam logic [1:0] OP_RUN    = 2'b01;
  localparam logic [1:0] OP_STEP   = 2'b10;
  localparam logic [1:0] OP_SET_BP = 2'b11;

  state_e                   state_q, state_d;
  logic                     bp_en_q, bp_en_d;
  logic [ROM_ADDR_BITS-1:0] bp_addr_q, bp_addr_d;
  logic [7:0]               step_cnt_q, step_cnt_d;
  logic                     skip_bp_q, skip_bp_d;
  logic                     bp_hit_q, bp_hit_d;

  logic cmd_ready_s;
  logic cmd_fire_s;
  logic bp_match_s;
  logic core_en_s;

  // Only some cmd_data bits are consumed depending on the op; fold the rest
  // into a sink so the whole bus is visibly used.
  logic unused_cmd_data_s;
  assign unused_cmd_data_s = ^cmd.cmd_data;

  // HALT is always takeable so the front end can stop a RUN/STEP at any time;
  // every other op waits for HALT. Depends on cmd_op only, never cmd_valid.
  assign cmd_ready_s   = (state_q == ST_HALT) | (cmd.cmd_op == OP_HALT);
  assign cmd.cmd_ready = cmd_ready_s;
  assign cmd_fire_s    = cmd.cmd_valid & cmd_ready_s;

  // skip_bp lets a RUN resumed from the breakpoint PC get past it once.
  assign bp_match_s = (state_q == ST_RUN) & bp_en_q & ~skip_bp_q &
                      (pc_word_i == bp_addr_q);

  // Core enable decode from the registered state and the live PC.
  always_comb begin
    core_en_s = 1'b0;
    case (state_q)
      ST_STEP: core_en_s = 1'b1;
      ST_RUN:  core_en_s = ~bp_match_s;
      ST_HALT: core_en_s = 1'b0;
      default: core_en_s = 1'b0;
    endcase
  end

  assign core_en_o = core_en_s;
  assign halted_o  = (state_q == ST_HALT);
  assign bp_hit_o  = bp_hit_q;

  // Next-state logic: command handling, breakpoint stop, step countdown.
  always_comb begin
    state_d    = state_q;
    bp_en_d    = bp_en_q;
    bp_addr_d  = bp_addr_q;
    step_cnt_d = step_cnt_q;
    skip_bp_d  = skip_bp_q;
    bp_hit_d   = bp_hit_q;

    case (state_q)
      ST_HALT: begin
        if (cmd_fire_s) begin
          case (cmd.cmd_op)
            OP_HALT: begin
              state_d = ST_HALT;
            end
            OP_RUN: begin
              state_d   = ST_RUN;
              skip_bp_d = 1'b1;
              bp_hit_d  = 1'b0;
            end
            OP_STEP: begin
              state_d    = ST_STEP;
              step_cnt_d = cmd.cmd_data;
              bp_hit_d   = 1'b0;
            end
            OP_SET_BP: begin
              bp_en_d   = cmd.cmd_data[7];
              bp_addr_d = cmd.cmd_data[ROM_ADDR_BITS-1:0];
            end
            default: begin
              state_d = ST_HALT;
            end
          endcase
        end else begin
          state_d = ST_HALT;
        end
      end

      ST_RUN: begin
        // Skip window covers only the first RUN cycle.
        skip_bp_d = 1'b0;
        // Breakpoint takes priority over a same-cycle HALT so bp_hit is set.
        if (bp_match_s) begin
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
        end else if (cmd_fire_s) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_STEP: begin
        // Every STEP cycle is a core_en cycle; step_cnt==0 marks the last one.
        if (cmd_fire_s) begin
          state_d    = ST_HALT;
          step_cnt_d = 8'd0;
        end else if (step_cnt_q == 8'd0) begin
          state_d = ST_HALT;
        end else begin
          step_cnt_d = step_cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_HALT;
      bp_en_q    <= 1'b0;
      bp_addr_q  <= {ROM_ADDR_BITS{1'b0}};
      step_cnt_q <= 8'd0;
      skip_bp_q  <= 1'b0;
      bp_hit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bp_en_q    <= bp_en_d;
      bp_addr_q  <= bp_addr_d;
      step_cnt_q <= step_cnt_d;
      skip_bp_q  <= skip_bp_d;
      bp_hit_q   <= bp_hit_d;
    end
  end

`ifdef RUN_CTRL_INSTRET_EN
  logic [15:0] instret_q, instret_d;

  // Saturating retired-instruction count.
  always_comb begin
    if (core_en_s && (instret_q != 16'hFFFF)) begin
      instret_d = instret_q + 16'd1;
    end else begin
      instret_d = instret_q;
    end
  end

  // Retired-instruction counter register; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= 16'h0000;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret_o = instret_q;
`else
  assign instret_o = 16'h0000;
`endif

endmodule : core_run_ctrl

// File: tb/tb_core_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_run_ctrl
//   Directed bench for core_run_ctrl. A behavioural model tracks the
//   sequencer's mode, the number of enable cycles still owed to a STEP, the
//   breakpoint setup and the resume-skip window; a negedge process compares
//   every DUT output against it each cycle. Directed scenarios add literal
//   expectations worked out by hand.
// -----------------------------------------------------------------------------
module tb_core_run_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pc_word;
  logic       core_en;
  logic       halted;
  logic       bp_hit;
  logic [15:0] instret;

  core_run_ctrl_if u_if ();

  core_run_ctrl #(.ROM_ADDR_BITS(4)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (u_if),
    .pc_word_i (pc_word),
    .core_en_o (core_en),
    .halted_o  (halted),
    .bp_hit_o  (bp_hit),
    .instret_o (instret)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 halted, 1 running, 2 stepping
  int m_mode   = 0;
  int m_left   = 0;   // enable cycles still owed to the current STEP
  bit m_first  = 0;   // first cycle of a RUN: breakpoint ignored
  bit m_bp_on  = 0;
  int m_bp_at  = 0;
  bit m_hit    = 0;
  int m_ret    = 0;

  function automatic bit m_stop_now();
    return (m_mode == 1) && m_bp_on && !m_first && (int'(pc_word) == m_bp_at);
  endfunction

  function automatic bit m_en_now();
    return (m_mode == 2) || ((m_mode == 1) && !m_stop_now());
  endfunction

  function automatic bit m_ready_now();
    return (m_mode == 0) || (u_if.cmd_op == 2'b00);
  endfunction

  always @(posedge clk) begin
    bit acc, stop, en;
    if (reset) begin
      m_mode = 0; m_left = 0; m_first = 0; m_bp_on = 0; m_bp_at = 0;
      m_hit = 0; m_ret = 0;
    end else begin
      acc  = u_if.cmd_valid && m_ready_now();
      stop = m_stop_now();
      en   = m_en_now();
`ifdef RUN_CTRL_INSTRET_EN
      if (en && m_ret != 65535) m_ret++;
`endif
      if (m_mode == 1) begin
        m_first = 0;
        if (stop) begin
          m_mode = 0; m_hit = 1;
        end else if (acc) begin
          m_mode = 0;
        end
      end else if (m_mode == 2) begin
        m_left--;
        if (acc || m_left == 0) begin
          m_mode = 0; m_left = 0;
        end
      end else if (acc) begin
        case (u_if.cmd_op)
          2'b01: begin m_mode = 1; m_first = 1; m_hit = 0; end
          2'b10: begin m_mode = 2; m_left = int'(u_if.cmd_data) + 1; m_hit = 0; end
          2'b11: begin m_bp_on = u_if.cmd_data[7]; m_bp_at = int'(u_if.cmd_data[3:0]); end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready", int'(u_if.cmd_ready), int'(m_ready_now()));
      check("core_en",   int'(core_en),        int'(m_en_now()));
      check("halted",    int'(halted),         int'(m_mode == 0));
      check("bp_hit",    int'(bp_hit),         int'(m_hit));
      check("instret",   int'(instret),        m_ret);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = op;
    u_if.cmd_data  = d;
    tick();
    u_if.cmd_valid = 1'b0;
    u_if.cmd_op    = 2'b00;
    u_if.cmd_data  = 8'h00;
    #1;
  endtask

  int cnt;
  int stop_pc;
  int exp_ret3;

  initial begin
    reset          = 1'b1;
    pc_word        = 4'd0;
    u_if.cmd_valid = 1'b0;
    u_if.cmd_op    = 2'b00;
    u_if.cmd_data  = 8'h00;
`ifdef RUN_CTRL_INSTRET_EN
    exp_ret3 = 3;
`else
    exp_ret3 = 0;
`endif
    tick(); tick();
    reset  = 1'b0;
    chk_en = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) tick();
    check("t1_halted",  int'(halted), 1);
    check("t1_core_en", int'(core_en), 0);
    check("t1_ready",   int'(u_if.cmd_ready), 1);
    check("t1_instret", int'(instret), 0);

    // 2: STEP count 3
    send(2'b10, 8'd2);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) check("t2_first_en", int'(core_en), 1);
      if (core_en) cnt++;
      tick();
    end
    check("t2_en_cycles", cnt, 3);
    check("t2_halted",    int'(halted), 1);
    check("t2_instret",   int'(instret), exp_ret3);

    // 2b: STEP with cmd_data=0 gives exactly one enable cycle
    send(2'b10, 8'd0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (core_en) cnt++;
      tick();
    end
    check("t2b_en_cycles", cnt, 1);

    // 3: breakpoint at word 5, PC counts up from 0
    send(2'b11, 8'h85);
    pc_word = 4'd0;
    send(2'b01, 8'h00);
    stop_pc = -1;
    for (int i = 0; i < 20; i++) begin
      if (!core_en) begin
        stop_pc = int'(pc_word);
        break;
      end
      tick();
      pc_word = pc_word + 4'd1;
      #1;
    end
    check("t3_stop_pc", stop_pc, 5);
    tick();
    check("t3_halted", int'(halted), 1);
    check("t3_bp_hit", int'(bp_hit), 1);

    // 4: resume at the breakpoint PC, then hit it again together with a HALT
    pc_word = 4'd5;
    send(2'b01, 8'h00);
    check("t4_skip_en", int'(core_en), 1);
    check("t4_bp_clr",  int'(bp_hit), 0);
    tick();
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = 2'b00;
    #1;
    check("t4_stop_en", int'(core_en), 0);
    tick();
    u_if.cmd_valid = 1'b0;
    #1;
    check("t4_halted", int'(halted), 1);
    check("t4_bp_win", int'(bp_hit), 1);

    // 5: STEP refused in RUN, HALT accepted with one cycle latency
    pc_word = 4'd0;
    send(2'b01, 8'h00);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = 2'b10;
    u_if.cmd_data  = 8'd3;
    #1;
    check("t5_step_refused", int'(u_if.cmd_ready), 0);
    tick();
    check("t5_still_run", int'(halted), 0);
    u_if.cmd_op = 2'b00;
    #1;
    check("t5_halt_ready", int'(u_if.cmd_ready), 1);
    check("t5_en_same_cyc", int'(core_en), 1);
    tick();
    u_if.cmd_valid = 1'b0;
    #1;
    check("t5_en_after", int'(core_en), 0);
    check("t5_halted",   int'(halted), 1);

    // 6: long STEP aborted by reset; breakpoint config cleared
    send(2'b11, 8'h85);
    pc_word = 4'd5;
    send(2'b10, 8'd200);
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t6_halted",  int'(halted), 1);
    check("t6_core_en", int'(core_en), 0);
    check("t6_instret", int'(instret), 0);
    check("t6_bp_hit",  int'(bp_hit), 0);
    send(2'b01, 8'h00);
    for (int i = 0; i < 4; i++) begin
      check("t6_bp_disabled", int'(core_en), 1);
      tick();
    end
    send(2'b00, 8'h00);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_core_run_ctrl
